// File: rtl/ifetch_prefetch.sv
// Instruction prefetcher: one outstanding byte fetch into a DEPTH-entry FIFO, flushed on redirect.
// Latency: ack-to-instr_valid 1 cycle (0 with IFETCH_BYPASS_EN when empty); stall holds the head, fetch throttles when full.
// Backpressure: stall=1 holds the FIFO head; fetch stops issuing once queued plus in-flight words would exceed DEPTH.
module ifetch_prefetch #(
   parameter int ADDR_W = 8,
   parameter int DEPTH  = 4
) (
   input  logic              clk,
   input  logic              rst,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_ack,
   input  logic [7:0]        mem_rdata,
   input  logic              redirect,
   input  logic [ADDR_W-1:0] redirect_pc,
   input  logic              stall,
   output logic [7:0]        instr_out,
   output logic [ADDR_W-1:0] instr_pc,
   output logic              instr_valid
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DROP} state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] fpc_q, fpc_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [7:0]        dat_q [DEPTH];
   logic [ADDR_W-1:0] pc_q  [DEPTH];

   logic fifo_empty;
   logic accept_ack;
   logic bypass_take;
   logic push;
   logic pop;

   assign fifo_empty = (count_q == '0);
   // Only an ack for a live (non-dropped) request carries a usable word.
   assign accept_ack = (state_q == S_WAIT) && mem_ack && !redirect;

`ifdef IFETCH_BYPASS_EN
   logic bypass_hit;
   assign bypass_hit  = accept_ack && fifo_empty;
   assign bypass_take = bypass_hit && !stall;
`else
   assign bypass_take = 1'b0;
`endif

   assign push = accept_ack && !bypass_take;
   assign pop  = !fifo_empty && !stall && !redirect;

   always_comb begin
      instr_valid = !fifo_empty;
      instr_out   = fifo_empty ? 8'h00 : dat_q[rd_ptr_q];
      instr_pc    = fifo_empty ? '0 : pc_q[rd_ptr_q];
`ifdef IFETCH_BYPASS_EN
      if (bypass_hit) begin
         instr_valid = 1'b1;
         instr_out   = mem_rdata;
         instr_pc    = fpc_q;
      end
`endif
   end

   assign mem_req  = (state_q != S_IDLE);
   assign mem_addr = addr_q;

   always_comb begin
      state_d = state_q;
      fpc_d   = fpc_q;
      addr_d  = addr_q;
      case (state_q)
         S_IDLE: begin
            // The FIFO only grows on an ack, so count<DEPTH here leaves room for the one in-flight word.
            if (!redirect && (count_q < FULL)) begin
               state_d = S_WAIT;
               addr_d  = fpc_q;
            end
         end
         S_WAIT: begin
            if (mem_ack) begin
               state_d = S_IDLE;
               if (!redirect) fpc_d = fpc_q + ADDR_W'(1);
            end else if (redirect) begin
               state_d = S_DROP;
            end
         end
         S_DROP: begin
            if (mem_ack) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      if (redirect) fpc_d = redirect_pc;
   end

   always_comb begin
      count_d  = count_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (redirect) begin
         count_d  = '0;
         wr_ptr_d = '0;
         rd_ptr_d = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
         case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= S_IDLE;
         fpc_q    <= '0;
         addr_q   <= '0;
         count_q  <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         state_q  <= state_d;
         fpc_q    <= fpc_d;
         addr_q   <= addr_d;
         count_q  <= count_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage needs no reset: outputs are gated by the count.
   always_ff @(posedge clk) begin
      if (push) begin
         dat_q[wr_ptr_q] <= mem_rdata;
         pc_q[wr_ptr_q]  <= fpc_q;
      end
   end

endmodule

// File: tb/tb_ifetch_prefetch.sv
// Directed bench for ifetch_prefetch: fetch order, throttling, redirects, wrap, reset abandonment, bypass.
module tb_ifetch_prefetch;

   logic       clk;
   logic       rst;
   logic       mem_req;
   logic [7:0] mem_addr;
   logic       mem_ack;
   logic [7:0] mem_rdata;
   logic       redirect;
   logic [7:0] redirect_pc;
   logic       stall;
   logic [7:0] instr_out;
   logic [7:0] instr_pc;
   logic       instr_valid;

   int errors = 0;
   int checks = 0;

   ifetch_prefetch #(.ADDR_W(8), .DEPTH(4)) dut (
      .clk         (clk),
      .rst         (rst),
      .mem_req     (mem_req),
      .mem_addr    (mem_addr),
      .mem_ack     (mem_ack),
      .mem_rdata   (mem_rdata),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .stall       (stall),
      .instr_out   (instr_out),
      .instr_pc    (instr_pc),
      .instr_valid (instr_valid)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_head(input string tag, input logic [7:0] d, input logic [7:0] pc);
      chk({tag, "_valid"}, {31'd0, instr_valid}, 32'd1);
      chk({tag, "_data"},  {24'd0, instr_out},   {24'd0, d});
      chk({tag, "_pc"},    {24'd0, instr_pc},    {24'd0, pc});
   endtask

   // Waits (bounded) for a request, checks its address, answers it with a one-cycle ack.
   task automatic serve(input logic [7:0] a, input logic [7:0] d);
      int n;
      n = 0;
      while (mem_req !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      chk("req_seen", {31'd0, mem_req}, 32'd1);
      chk("req_addr", {24'd0, mem_addr}, {24'd0, a});
      mem_ack   = 1'b1;
      mem_rdata = d;
      tick();
      mem_ack   = 1'b0;
      #1;
   endtask

   initial begin
      rst         = 1'b0;
      stall       = 1'b1;
      redirect    = 1'b0;
      redirect_pc = 8'h00;
      mem_ack     = 1'b0;
      mem_rdata   = 8'h00;
      repeat (3) tick();
      chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
      chk("rst_mem_addr", {24'd0, mem_addr}, 32'd0);
      chk("rst_valid", {31'd0, instr_valid}, 32'd0);
      chk("rst_instr", {24'd0, instr_out}, 32'd0);
      chk("rst_pc", {24'd0, instr_pc}, 32'd0);

      // First request on the first edge after release, to address 0.
      rst = 1'b1;
      tick();
      chk("first_req", {31'd0, mem_req}, 32'd1);
      chk("first_addr", {24'd0, mem_addr}, 32'd0);

      // Fill under stall: four words, then no further requests.
      serve(8'h00, 8'h11);
      chk_head("fill1", 8'h11, 8'h00);
      serve(8'h01, 8'h22);
      serve(8'h02, 8'h33);
      serve(8'h03, 8'h44);
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("throttle_no_req", {31'd0, mem_req}, 32'd0);
      end
      chk_head("full_head", 8'h11, 8'h00);

      // Drain in order.
      stall = 1'b0;
      #1;
      chk_head("drain0", 8'h11, 8'h00);
      tick();
      chk_head("drain1", 8'h22, 8'h01);
      tick();
      chk_head("drain2", 8'h33, 8'h02);
      tick();
      chk_head("drain3", 8'h44, 8'h03);
      tick();
      chk("drain_empty", {31'd0, instr_valid}, 32'd0);
      chk("refetch_addr", {24'd0, mem_addr}, 32'h04);
      stall = 1'b1;

      // Redirect to 0x05 while the fetch of 0x04 is pending: that data is dropped.
      redirect    = 1'b1;
      redirect_pc = 8'h05;
      tick();
      redirect = 1'b0;
      #1;
      chk("drop_req_held", {31'd0, mem_req}, 32'd1);
      chk("drop_addr_held", {24'd0, mem_addr}, 32'h04);
      chk("redir_valid0", {31'd0, instr_valid}, 32'd0);
      mem_ack   = 1'b1;
      mem_rdata = 8'hEE;
      tick();
      mem_ack = 1'b0;
      #1;
      chk("drop_discard", {31'd0, instr_valid}, 32'd0);
      tick();
      chk("req_05", {31'd0, mem_req}, 32'd1);
      chk("req_05_addr", {24'd0, mem_addr}, 32'h05);

      // Redirect in WAIT (to 0x30), then again in DROP (to 0x40).
      redirect    = 1'b1;
      redirect_pc = 8'h30;
      tick();
      redirect_pc = 8'h40;
      #1;
      chk("drop2_addr_held", {24'd0, mem_addr}, 32'h05);
      chk("redir2_valid0", {31'd0, instr_valid}, 32'd0);
      tick();
      redirect = 1'b0;
      #1;
      chk("drop3_req_held", {31'd0, mem_req}, 32'd1);
      mem_ack   = 1'b1;
      mem_rdata = 8'h55;
      tick();
      mem_ack = 1'b0;
      #1;
      chk("drop_05_discard", {31'd0, instr_valid}, 32'd0);
      serve(8'h40, 8'h66);
      chk_head("after_redir", 8'h66, 8'h40);

      // Address wrap 0xFE, 0xFF, 0x00; redirect also flushes the queued 0x40 word.
      redirect    = 1'b1;
      redirect_pc = 8'hFE;
      tick();
      redirect = 1'b0;
      #1;
      chk("flush_valid0", {31'd0, instr_valid}, 32'd0);
      serve(8'hFE, 8'hA1);
      serve(8'hFF, 8'hA2);
      serve(8'h00, 8'hA3);
      stall = 1'b0;
      #1;
      chk_head("wrap0", 8'hA1, 8'hFE);
      tick();
      chk_head("wrap1", 8'hA2, 8'hFF);
      tick();
      chk_head("wrap2", 8'hA3, 8'h00);
      tick();
      chk("wrap_empty", {31'd0, instr_valid}, 32'd0);
      stall = 1'b1;

      // An ack arriving in IDLE must not push anything.
      serve(8'h01, 8'hC1);
      mem_ack   = 1'b1;
      mem_rdata = 8'hBB;
      tick();
      mem_ack = 1'b0;
      #1;
      chk_head("idle_ack_head", 8'hC1, 8'h01);
      stall = 1'b0;
      tick();
      chk("idle_ack_ignored", {31'd0, instr_valid}, 32'd0);
      stall = 1'b1;

      // Reset mid-request with a queued word: outputs clear without a clock edge.
      serve(8'h02, 8'hC2);
      tick();
      chk("pre_rst_req", {31'd0, mem_req}, 32'd1);
      rst = 1'b0;
      #1;
      chk("async_rst_req", {31'd0, mem_req}, 32'd0);
      chk("async_rst_addr", {24'd0, mem_addr}, 32'd0);
      chk("async_rst_valid", {31'd0, instr_valid}, 32'd0);
      chk("async_rst_instr", {24'd0, instr_out}, 32'd0);
      chk("async_rst_pc", {24'd0, instr_pc}, 32'd0);
      tick();
      tick();
      rst       = 1'b1;
      mem_ack   = 1'b1;
      mem_rdata = 8'hDD;
      tick();
      mem_ack = 1'b0;
      #1;
      chk("late_ack_ignored", {31'd0, instr_valid}, 32'd0);
      chk("refetch0_req", {31'd0, mem_req}, 32'd1);
      chk("refetch0_addr", {24'd0, mem_addr}, 32'd0);
      serve(8'h00, 8'h77);
      chk_head("refetch0_data", 8'h77, 8'h00);

      // Empty FIFO, ack with stall=0: bypass shows the word in the ack cycle.
      stall = 1'b0;
      tick();
      chk("byp_req_addr", {24'd0, mem_addr}, 32'h01);
      mem_ack   = 1'b1;
      mem_rdata = 8'h5A;
      #1;
`ifdef IFETCH_BYPASS_EN
      chk_head("bypass_same_cycle", 8'h5A, 8'h01);
      tick();
      mem_ack = 1'b0;
      #1;
      chk("bypass_not_pushed", {31'd0, instr_valid}, 32'd0);
`else
      chk("nobypass_ack_cycle", {31'd0, instr_valid}, 32'd0);
      tick();
      mem_ack = 1'b0;
      #1;
      chk_head("nobypass_next", 8'h5A, 8'h01);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
